// File: rtl/rw_device_sched.sv
// rw_device_sched: round-robin front end that shares one single-word,
// one-step-per-enable device between two requesters. One transaction is
// in flight at a time; a device termination (continue flag low) parks
// the scheduler in HALT until an explicit restart.
module rw_device_sched #(
  parameter int W_IN  = 1,
  parameter int W_OUT = 1,
  parameter int LAT   = 1,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*W_IN-1:0]   req_data,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [W_OUT-1:0]    rsp_data,
  output logic                rsp_last,
  input  logic [1:0]          rsp_ready,
  output logic [W_IN-1:0]     dev_in,
  output logic                dev_step,
  input  logic [W_OUT-1:0]    dev_out,
  input  logic                dev_cont,
  output logic                dev_restart,
  input  logic                restart,
  output logic                halted,
  output logic [CW-1:0]       cnt0,
  output logic [CW-1:0]       cnt1
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Wait counter starts at LAT-1 so the sample lands LAT cycles after the step.
  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               g_q, g_d;
  logic [W_IN-1:0]    dev_in_q, dev_in_d;
  logic [W_OUT-1:0]   rsp_data_q, rsp_data_d;
  logic               rsp_last_q, rsp_last_d;
  logic [CW-1:0]      cnt0_q, cnt0_d;
  logic [CW-1:0]      cnt1_q, cnt1_d;
  logic [3:0]         wait_q, wait_d;

  logic               gnt_valid;
  logic               gnt;
  logic               ptr_other;

  assign ptr_other = ~ptr_q;

  // Round-robin pick: the pointed-to requester wins if valid, else the other.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = ptr_q;
    if (req_valid[ptr_q]) begin
      gnt_valid = 1'b1;
      gnt       = ptr_q;
    end else if (req_valid[ptr_other]) begin
      gnt_valid = 1'b1;
      gnt       = ptr_other;
    end
  end

  // Next-state and datapath updates for the transaction FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    g_d        = g_q;
    dev_in_d   = dev_in_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          g_d      = gnt;
          dev_in_d = gnt ? req_data[W_IN +: W_IN] : req_data[0 +: W_IN];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_d  = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 4'd0) begin
          rsp_data_d = dev_out;
          rsp_last_d = ~dev_cont;
          state_d    = S_RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        // Only the granted requester's ready bit completes the response.
        if (rsp_ready[g_q]) begin
          if (g_q) cnt1_d = cnt1_q + CW'(1);
          else     cnt0_d = cnt0_q + CW'(1);
          ptr_d   = ~g_q;
          state_d = rsp_last_q ? S_HALT : S_IDLE;
        end
      end
      S_HALT: begin
        if (restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      g_q        <= 1'b0;
      dev_in_q   <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      wait_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      g_q        <= g_d;
      dev_in_q   <= dev_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      wait_q     <= wait_d;
    end
  end

  // Outputs decoded from state; req_ready is held low while reset is asserted.
  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    dev_step    = 1'b0;
    dev_restart = 1'b0;
    halted      = 1'b0;
    if (rst && (state_q == S_IDLE) && gnt_valid) req_ready = gnt ? 2'b10 : 2'b01;
    if (state_q == S_RESP) rsp_valid = g_q ? 2'b10 : 2'b01;
    if (state_q == S_ISSUE) dev_step = 1'b1;
    if (state_q == S_HALT) begin
      halted      = 1'b1;
      dev_restart = restart;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_last = rsp_last_q;
  assign dev_in   = dev_in_q;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule

// File: tb/tb_rw_device_sched.sv
// Directed bench for rw_device_sched: DUT 0 uses LAT=1/CW=8, DUT 1 uses
// LAT=4/CW=2 for the latency, wrap and mid-WAIT reset cases.
module tb_rw_device_sched;

  logic       clk;
  logic       rst_n       [2];
  logic [1:0] req_valid   [2];
  logic [1:0] req_data    [2];
  logic [1:0] req_ready   [2];
  logic [1:0] rsp_valid   [2];
  logic       rsp_data    [2];
  logic       rsp_last    [2];
  logic [1:0] rsp_ready   [2];
  logic       dev_in      [2];
  logic       dev_step    [2];
  logic       dev_out     [2];
  logic       dev_cont    [2];
  logic       dev_restart [2];
  logic       restart     [2];
  logic       halted      [2];
  logic [7:0] cnt0_a, cnt1_a;
  logic [1:0] cnt0_b, cnt1_b;
  int         steps       [2];
  int         n_total;
  int         n_bad;

  rw_device_sched #(.W_IN(1), .W_OUT(1), .LAT(1), .CW(8)) dut_a (
    .clk(clk), .rst(rst_n[0]),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_ready(req_ready[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_last(rsp_last[0]),
    .rsp_ready(rsp_ready[0]), .dev_in(dev_in[0]), .dev_step(dev_step[0]),
    .dev_out(dev_out[0]), .dev_cont(dev_cont[0]), .dev_restart(dev_restart[0]),
    .restart(restart[0]), .halted(halted[0]), .cnt0(cnt0_a), .cnt1(cnt1_a)
  );

  rw_device_sched #(.W_IN(1), .W_OUT(1), .LAT(4), .CW(2)) dut_b (
    .clk(clk), .rst(rst_n[1]),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_ready(req_ready[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_last(rsp_last[1]),
    .rsp_ready(rsp_ready[1]), .dev_in(dev_in[1]), .dev_step(dev_step[1]),
    .dev_out(dev_out[1]), .dev_cont(dev_cont[1]), .dev_restart(dev_restart[1]),
    .restart(restart[1]), .halted(halted[1]), .cnt0(cnt0_b), .cnt1(cnt1_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count device step pulses per DUT.
  always @(posedge clk) begin
    if (dev_step[0]) steps[0] <= steps[0] + 1;
    if (dev_step[1]) steps[1] <= steps[1] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs(input int d);
    req_valid[d] = 2'b00;
    req_data[d]  = 2'b00;
    rsp_ready[d] = 2'b00;
    dev_out[d]   = 1'b0;
    dev_cont[d]  = 1'b1;
    restart[d]   = 1'b0;
  endtask

  task automatic do_reset(input int d);
    idle_inputs(d);
    rst_n[d] = 1'b0;
    repeat (3) cyc();
    rst_n[d] = 1'b1;
  endtask

  // Full transaction with immediate response consumption; one line per transaction.
  task automatic run_txn(input int d, input logic [1:0] rv, input logic [1:0] rd,
                         input logic dout, input logic cont, output logic [1:0] gnt_o);
    bit seen;
    req_valid[d] = rv;
    req_data[d]  = rd;
    dev_out[d]   = dout;
    dev_cont[d]  = cont;
    rsp_ready[d] = 2'b11;
    gnt_o = 2'b00;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (req_ready[d] != 2'b00) begin
        gnt_o = req_ready[d];
        seen  = 1'b1;
      end
      cyc();
    end
    req_valid[d] = 2'b00;
    chk("txn_accept", {31'b0, seen}, 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      #1;
      if (rsp_valid[d] != 2'b00) seen = 1'b1;
      cyc();
    end
    chk("txn_response", {31'b0, seen}, 32'd1);
    rsp_ready[d] = 2'b00;
    $display("txn dut%0d gnt=%b data=%b dout=%b cont=%b", d, gnt_o, rd, dout, cont);
  endtask

  // LAT=4 capture point: dev_out is v only in the sampled cycle, ~v either side.
  task automatic lat_txn(input logic v);
    req_valid[1] = 2'b10;
    req_data[1]  = 2'b10;
    dev_out[1]   = ~v;
    dev_cont[1]  = 1'b1;
    rsp_ready[1] = 2'b11;
    #1 chk("lat_accept", {30'b0, req_ready[1]}, 32'h2);
    cyc();                                   // T+1
    req_valid[1] = 2'b00;
    #1 chk("lat_step", {31'b0, dev_step[1]}, 32'd1);
    cyc(); cyc(); cyc();                     // T+4
    dev_out[1] = ~v;
    cyc();                                   // T+5: sample point
    dev_out[1] = v;
    #1 chk("lat_not_yet", {30'b0, rsp_valid[1]}, 32'h0);
    cyc();                                   // T+6
    dev_out[1] = ~v;
    #1 chk("lat_rsp_valid", {30'b0, rsp_valid[1]}, 32'h2);
    chk("lat_rsp_data", {31'b0, rsp_data[1]}, {31'b0, v});
    cyc();
    rsp_ready[1] = 2'b00;
    $display("txn dut1 lat check v=%b", v);
  endtask

  initial begin
    logic [1:0] g;
    int         k;
    int         s0;
    bit         leak;
    n_total = 0;
    n_bad   = 0;
    steps[0] = 0;
    steps[1] = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      idle_inputs(d);
    end

    // Reset state on both DUTs.
    repeat (3) cyc();
    #1;
    chk("rst_rsp_valid_a", {30'b0, rsp_valid[0]}, 32'h0);
    chk("rst_dev_step_a", {31'b0, dev_step[0]}, 32'h0);
    chk("rst_halted_a", {31'b0, halted[0]}, 32'h0);
    chk("rst_cnt0_a", {24'b0, cnt0_a}, 32'h0);
    chk("rst_dev_in_b", {31'b0, dev_in[1]}, 32'h0);
    chk("rst_cnt1_b", {30'b0, cnt1_b}, 32'h0);
    cyc();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Single request on requester 0, echo device, LAT=1.
    req_valid[0] = 2'b01;
    req_data[0]  = 2'b01;
    dev_out[0]   = 1'b1;
    dev_cont[0]  = 1'b1;
    #1 chk("single_ready", {30'b0, req_ready[0]}, 32'h1);
    cyc();
    req_valid[0] = 2'b00;
    #1 chk("single_step", {31'b0, dev_step[0]}, 32'h1);
    chk("single_dev_in", {31'b0, dev_in[0]}, 32'h1);
    cyc();
    #1 chk("single_step_off", {31'b0, dev_step[0]}, 32'h0);
    chk("single_no_rsp_yet", {30'b0, rsp_valid[0]}, 32'h0);
    cyc();
    #1 chk("single_rsp_valid", {30'b0, rsp_valid[0]}, 32'h1);
    chk("single_rsp_data", {31'b0, rsp_data[0]}, 32'h1);
    chk("single_rsp_last", {31'b0, rsp_last[0]}, 32'h0);
    rsp_ready[0] = 2'b01;
    cyc();
    rsp_ready[0] = 2'b00;
    #1 chk("single_cnt0", {24'b0, cnt0_a}, 32'h1);
    chk("single_rsp_done", {30'b0, rsp_valid[0]}, 32'h0);
    $display("txn dut0 single req0 data=1");

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    do_reset(0);
    s0 = steps[0];
    req_valid[0] = 2'b11;
    req_data[0]  = 2'b10;
    rsp_ready[0] = 2'b11;
    k = 0;
    for (int c = 0; c < 100 && k < 4; c++) begin
      #1;
      if (req_ready[0] != 2'b00) begin
        chk("grant_order", {30'b0, req_ready[0]}, (k % 2 == 1) ? 32'h2 : 32'h1);
        $display("txn dut0 contention grant=%b", req_ready[0]);
        k++;
      end
      cyc();
    end
    req_valid[0] = 2'b00;
    chk("grant_count", k, 32'd4);
    repeat (6) cyc();
    rsp_ready[0] = 2'b00;
    #1 chk("cont_cnt0", {24'b0, cnt0_a}, 32'h2);
    chk("cont_cnt1", {24'b0, cnt1_a}, 32'h2);
    chk("cont_steps", steps[0] - s0, 32'd4);

    // Backpressure on requester 0 (ptr now 0).
    req_valid[0] = 2'b01;
    req_data[0]  = 2'b00;
    dev_out[0]   = 1'b1;
    #1 chk("bp_ready", {30'b0, req_ready[0]}, 32'h1);
    cyc();
    req_valid[0] = 2'b00;
    cyc(); cyc();
    #1 chk("bp_rsp_valid", {30'b0, rsp_valid[0]}, 32'h1);
    req_valid[0] = 2'b11;
    dev_out[0]   = 1'b0;
    s0 = steps[0];
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", {30'b0, rsp_valid[0]}, 32'h1);
      chk("bp_hold_data", {31'b0, rsp_data[0]}, 32'h1);
      chk("bp_no_ready", {30'b0, req_ready[0]}, 32'h0);
      chk("bp_no_step", {31'b0, dev_step[0]}, 32'h0);
      cyc();
    end
    req_valid[0] = 2'b00;
    rsp_ready[0] = 2'b01;
    cyc();
    rsp_ready[0] = 2'b00;
    #1 chk("bp_cnt0", {24'b0, cnt0_a}, 32'h3);
    chk("bp_released", {30'b0, rsp_valid[0]}, 32'h0);
    cyc();
    #1 chk("bp_cnt0_once", {24'b0, cnt0_a}, 32'h3);
    chk("bp_steps", steps[0] - s0, 32'd0);
    $display("txn dut0 backpressure req0");

    // Termination on requester 0 (ptr 1, only 0 valid).
    req_valid[0] = 2'b01;
    req_data[0]  = 2'b01;
    dev_out[0]   = 1'b1;
    dev_cont[0]  = 1'b0;
    #1 chk("term_ready", {30'b0, req_ready[0]}, 32'h1);
    cyc();
    req_valid[0] = 2'b00;
    cyc(); cyc();
    #1 chk("term_rsp_valid", {30'b0, rsp_valid[0]}, 32'h1);
    chk("term_rsp_last", {31'b0, rsp_last[0]}, 32'h1);
    rsp_ready[0] = 2'b01;
    req_valid[0] = 2'b11;
    cyc();
    rsp_ready[0] = 2'b00;
    #1 chk("term_halted", {31'b0, halted[0]}, 32'h1);
    chk("term_no_ready", {30'b0, req_ready[0]}, 32'h0);
    chk("term_cnt0", {24'b0, cnt0_a}, 32'h4);
    cyc();
    #1 chk("halt_still", {31'b0, halted[0]}, 32'h1);
    chk("halt_no_step", {31'b0, dev_step[0]}, 32'h0);
    chk("halt_no_restart", {31'b0, dev_restart[0]}, 32'h0);
    restart[0] = 1'b1;
    #1 chk("restart_pulse", {31'b0, dev_restart[0]}, 32'h1);
    cyc();
    restart[0] = 1'b0;
    #1 chk("restart_unhalted", {31'b0, halted[0]}, 32'h0);
    chk("restart_pulse_off", {31'b0, dev_restart[0]}, 32'h0);
    chk("restart_next_grant", {30'b0, req_ready[0]}, 32'h2);
    req_valid[0] = 2'b00;
    restart[0]   = 1'b1;
    #1 chk("restart_ignored", {31'b0, dev_restart[0]}, 32'h0);
    restart[0]   = 1'b0;
    dev_cont[0]  = 1'b1;
    $display("txn dut0 termination and restart");

    // LAT=4 capture point and CW=2 wrap on requester 1.
    lat_txn(1'b0);
    lat_txn(1'b1);
    #1 chk("wrap_cnt1_2", {30'b0, cnt1_b}, 32'h2);
    run_txn(1, 2'b10, 2'b10, 1'b1, 1'b1, g);
    chk("wrap_grant", {30'b0, g}, 32'h2);
    run_txn(1, 2'b10, 2'b10, 1'b1, 1'b1, g);
    #1 chk("wrap_cnt1_0", {30'b0, cnt1_b}, 32'h0);
    run_txn(1, 2'b10, 2'b10, 1'b0, 1'b1, g);
    #1 chk("wrap_cnt1_1", {30'b0, cnt1_b}, 32'h1);
    chk("wrap_cnt0", {30'b0, cnt0_b}, 32'h0);

    // Asynchronous reset while in WAIT.
    cyc();
    req_valid[1] = 2'b10;
    req_data[1]  = 2'b10;
    dev_out[1]   = 1'b1;
    #1 chk("arst_accept", {30'b0, req_ready[1]}, 32'h2);
    cyc();
    req_valid[1] = 2'b00;
    cyc();
    #1 rst_n[1] = 1'b0;
    #1;
    chk("arst_dev_in", {31'b0, dev_in[1]}, 32'h0);
    chk("arst_cnt1", {30'b0, cnt1_b}, 32'h0);
    chk("arst_rsp_valid", {30'b0, rsp_valid[1]}, 32'h0);
    chk("arst_dev_step", {31'b0, dev_step[1]}, 32'h0);
    cyc(); cyc();
    rst_n[1] = 1'b1;
    rsp_ready[1] = 2'b11;
    s0 = steps[1];
    leak = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rsp_valid[1] != 2'b00) leak = 1'b1;
      cyc();
    end
    chk("arst_no_rsp", {31'b0, leak}, 32'h0);
    chk("arst_no_step", steps[1] - s0, 32'd0);
    $display("txn dut1 async reset in WAIT");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
